// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: memory geometry, the
// arbiter state encoding and the address-fault constants.
package dmem_pkg;

  // Memory geometry: DEPTH doublewords of DATA_W bits each
  localparam int DEPTH  = 1024;
  localparam int IDX_W  = 10;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 64;

  // Fault checking: the low OFS_W address bits select a byte inside a
  // doubleword and must be zero; every bit at or above IDX_W + OFS_W
  // lies outside the memory and must also be zero.
  localparam int OFS_W       = 3;
  localparam int RANGE_LSB   = IDX_W + OFS_W;
  localparam logic [OFS_W-1:0] ALIGN_OK = '0;

  // Arbiter sequencing: wait for a request, run the access, report back
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_bank.sv
// dmem_bank: single-port DEPTH x 64 storage with synchronous write and a
// registered read port. Contents are not touched by reset.
module dmem_bank #(
  parameter int DEPTH = dmem_pkg::DEPTH,
  parameter int IDX_W = dmem_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [63:0]      wdata_i,
  output logic [63:0]      rdata_o
);
  import dmem_pkg::*;

  // Storage starts out all-zero at power-up only; there is no clear path
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] rdata_q;

  // One operation per enabled edge: either write the word or capture it
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem[idx_i] <= wdata_i;
      end else begin
        rdata_q <= mem[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter letting the load/store unit (0) and the
// debug/DMA port (1) share one single-port data memory. Each access takes a
// grant cycle followed by a response cycle.
module dmem_arbiter #(
  parameter int DEPTH = dmem_pkg::DEPTH,
  parameter int IDX_W = dmem_pkg::IDX_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [63:0] addr0,
  input  logic [63:0] addr1,
  input  logic [63:0] wdata0,
  input  logic [63:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [63:0] rdata0,
  output logic [63:0] rdata1,
  output logic        err0,
  output logic        err1
);
  import dmem_pkg::*;

  localparam int HI_LSB = IDX_W + OFS_W;

  state_e           state_q;
  logic [1:0]       gnt_q;
  logic [1:0]       rvalid_q;
  logic [1:0]       err_q;
  logic             lastGnt_q;
  logic             win_q;
  logic             we_q;
  logic             fault_q;
  logic [IDX_W-1:0] idx_q;
  logic [63:0]      wdata_q;

  logic             anyReq_d;
  logic             win_d;
  logic             we_d;
  logic             fault_d;
  logic [63:0]      addr_d;
  logic [63:0]      wdata_d;
  logic [IDX_W-1:0] idx_d;
  logic [1:0]       winSel_d;
  logic [1:0]       curSel;

  logic             bankEn;
  logic             loadHit;
  logic [63:0]      bankRdata;

  // Pick the next winner: on contention the requester not granted last wins,
  // a lone request always wins; then decode the winner's address
  always_comb begin
    anyReq_d = req0 | req1;
    if (req0 && req1) begin
      win_d = ~lastGnt_q;
    end else begin
      win_d = req1;
    end
    we_d     = win_d ? we1    : we0;
    addr_d   = win_d ? addr1  : addr0;
    wdata_d  = win_d ? wdata1 : wdata0;
    idx_d    = addr_d[HI_LSB-1:OFS_W];
    fault_d  = (addr_d[OFS_W-1:0] != ALIGN_OK) || (addr_d[63:HI_LSB] != '0);
    winSel_d = win_d ? 2'b10 : 2'b01;
  end

  assign curSel = win_q ? 2'b10 : 2'b01;

  // Arbiter sequencer: latch the winner's request, pulse its grant, then
  // pulse its response; a request seen during the response cycle starts the
  // next access immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      rvalid_q  <= '0;
      err_q     <= '0;
      lastGnt_q <= 1'b1;
      win_q     <= 1'b0;
      we_q      <= 1'b0;
      fault_q   <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
    end else begin
      gnt_q    <= '0;
      rvalid_q <= '0;
      err_q    <= '0;
      unique case (state_q)
        IDLE, RESP: begin
          if (anyReq_d) begin
            state_q   <= ACCESS;
            gnt_q     <= winSel_d;
            lastGnt_q <= win_d;
            win_q     <= win_d;
            we_q      <= we_d;
            fault_q   <= fault_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
          end else begin
            state_q <= IDLE;
          end
        end
        ACCESS: begin
          state_q  <= RESP;
          rvalid_q <= curSel;
          err_q    <= fault_q ? curSel : 2'b00;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The memory is only touched at the closing edge of a fault-free access;
  // a reset during ACCESS drops the enable before that edge arrives
  assign bankEn = (state_q == ACCESS) && !fault_q;

  dmem_bank #(
    .DEPTH(DEPTH),
    .IDX_W(IDX_W)
  ) uBank (
    .clk    (clk),
    .en_i   (bankEn),
    .we_i   (we_q),
    .idx_i  (idx_q),
    .wdata_i(wdata_q),
    .rdata_o(bankRdata)
  );

  // Only a clean load returns memory data; stores and faults return zero
  assign loadHit = !we_q && !fault_q;

  assign gnt0    = gnt_q[0];
  assign gnt1    = gnt_q[1];
  assign rvalid0 = rvalid_q[0];
  assign rvalid1 = rvalid_q[1];
  assign err0    = err_q[0];
  assign err1    = err_q[1];
  assign rdata0  = (rvalid_q[0] && loadHit) ? bankRdata : '0;
  assign rdata1  = (rvalid_q[1] && loadHit) ? bankRdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized two-requester traffic,
// checked every cycle against a transaction-level model of the arbiter.
module tb_dmem_arbiter;

  localparam int MDEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [63:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [63:0] rdata0, rdata1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model state: expected outputs for the current cycle and the response
  // already scheduled for the next one
  logic [63:0] mem [MDEPTH];
  logic [1:0]  expGnt = '0, expRv = '0, expErr = '0;
  logic [63:0] expRd0 = '0, expRd1 = '0;
  logic [1:0]  pendRv = '0, pendErr = '0;
  logic [63:0] pendRd0 = '0, pendRd1 = '0;
  logic        busy = 1'b0;
  logic        lastG = 1'b1;
  logic        wrPend = 1'b0;
  int          wrIdx = 0;
  logic [63:0] wrData = '0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1)
  );

  // Power-up memory image is all zero
  initial begin
    for (int i = 0; i < MDEPTH; i++) mem[i] = '0;
  end

  // Cycle counter used to measure grant/response latencies
  always @(posedge clk) cyc <= cyc + 1;

  // Transaction model: the arbiter can accept a request at an edge unless it
  // accepted one at the previous edge; the accepted request is granted in the
  // next cycle and answered in the one after. Stores land one edge later, so
  // a reset in between cancels them.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expGnt <= '0; expRv <= '0; expErr <= '0; expRd0 <= '0; expRd1 <= '0;
      pendRv <= '0; pendErr <= '0; pendRd0 <= '0; pendRd1 <= '0;
      busy <= 1'b0; lastG <= 1'b1; wrPend <= 1'b0;
    end else begin : modelStep
      logic [1:0]  rq;
      logic        w, isSt, flt;
      logic [63:0] a, d, rdv;
      if (wrPend) mem[wrIdx] <= wrData;
      wrPend <= 1'b0;
      expGnt <= '0;
      expRv <= pendRv; expErr <= pendErr; expRd0 <= pendRd0; expRd1 <= pendRd1;
      pendRv <= '0; pendErr <= '0; pendRd0 <= '0; pendRd1 <= '0;
      rq = {req1, req0};
      if (busy) begin
        busy <= 1'b0;
      end else if (rq != 2'b00) begin
        w    = (rq == 2'b11) ? !lastG : rq[1];
        isSt = w ? we1 : we0;
        a    = w ? addr1 : addr0;
        d    = w ? wdata1 : wdata0;
        flt  = (a % 8 != 0) || (a >= 64'(MDEPTH) * 8);
        rdv  = '0;
        if (!flt && !isSt) rdv = mem[int'(a / 8)];
        if (!flt && isSt) begin
          wrPend <= 1'b1; wrIdx <= int'(a / 8); wrData <= d;
        end
        expGnt  <= w ? 2'b10 : 2'b01;
        pendRv  <= w ? 2'b10 : 2'b01;
        pendErr <= flt ? (w ? 2'b10 : 2'b01) : 2'b00;
        if (w) pendRd1 <= rdv; else pendRd0 <= rdv;
        lastG <= w;
        busy  <= 1'b1;
      end
    end
  end

  // Single comparison point: records one check and reports any difference
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every cycle the DUT outputs must match what the model predicts
  always @(negedge clk) begin
    checkOutput("gnt", 64'({gnt1, gnt0}), 64'(expGnt));
    checkOutput("rvalid", 64'({rvalid1, rvalid0}), 64'(expRv));
    checkOutput("err", 64'({err1, err0}), 64'(expErr));
    if (expRv[0]) checkOutput("rdata0", rdata0, expRd0);
    if (expRv[1]) checkOutput("rdata1", rdata1, expRd1);
  end

  // Drives one requester's request lines
  task automatic drive(input int i, input logic r, input logic w, input logic [63:0] a, input logic [63:0] d);
    if (i == 0) begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end
  endtask

  function automatic logic gntOf(input int i);
    return (i == 0) ? gnt0 : gnt1;
  endfunction

  function automatic logic rvalidOf(input int i);
    return (i == 0) ? rvalid0 : rvalid1;
  endfunction

  // Issues one access, holds it until granted, then drops req.
  // lat is the number of cycles from issue to grant.
  task automatic applyStimulus(input int i, input logic w, input logic [63:0] a,
                               input logic [63:0] d, output int lat, output int gCyc);
    int  issue;
    bit  seen;
    issue = cyc;
    seen  = 1'b0;
    lat   = -1;
    gCyc  = -1;
    drive(i, 1'b1, w, a, d);
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (gntOf(i)) begin
        seen = 1'b1;
        lat  = cyc - issue;
        gCyc = cyc;
        drive(i, 1'b0, 1'b0, '0, '0);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL grant_timeout req%0d: got none expected gnt within 40 cycles", i);
      drive(i, 1'b0, 1'b0, '0, '0);
    end
  endtask

  // Waits for the response pulse of requester i
  task automatic waitResp(input int i, output logic [63:0] rd, output logic e);
    bit seen;
    seen = 1'b0;
    rd = '0;
    e = 1'b0;
    for (int n = 0; n < 5 && !seen; n++) begin
      @(negedge clk);
      if (rvalidOf(i)) begin
        seen = 1'b1;
        rd = (i == 0) ? rdata0 : rdata1;
        e  = (i == 0) ? err0 : err1;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL resp_timeout req%0d: got none expected rvalid within 5 cycles", i);
    end
  endtask

  // Mostly small aligned addresses so loads hit earlier stores, with some
  // misaligned, out-of-range and top-of-memory addresses mixed in
  function automatic logic [63:0] randAddr();
    int sel;
    logic [63:0] a;
    sel = $urandom_range(0, 9);
    if (sel < 6)       a = 64'($urandom_range(0, 15)) << 3;
    else if (sel == 6) a = (64'($urandom_range(0, 15)) << 3) | 64'($urandom_range(1, 7));
    else if (sel == 7) a = (64'(1) << $urandom_range(13, 63)) | (64'($urandom_range(0, 15)) << 3);
    else               a = 64'(MDEPTH - 1 - $urandom_range(0, 3)) << 3;
    return a;
  endfunction

  // Randomized requester: random gaps (zero gap means back-to-back)
  task automatic randomRequester(input int i, input int count);
    int lat, gc;
    for (int k = 0; k < count; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      applyStimulus(i, 1'($urandom_range(0, 1)), randAddr(), {$urandom, $urandom}, lat, gc);
    end
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Guard against a stalled run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by random traffic
  initial begin
    logic [63:0] rd;
    logic        e;
    int          lat, g1, g2;
    int          order [5];
    int          gcyc [5];
    int          ng;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_flags", 64'({gnt1, gnt0, rvalid1, rvalid0, err1, err0}), 64'h0);
    checkOutput("reset_rdata", rdata0 | rdata1, 64'h0);
    rst_n = 1'b1;

    // First load after reset: grant after one cycle, response after two
    applyStimulus(0, 1'b0, 64'h18, '0, lat, g1);
    checkOutput("t023_gnt_latency", 64'(lat), 64'd1);
    checkOutput("t023_model_gnt", 64'(expGnt), 64'h1);
    waitResp(0, rd, e);
    checkOutput("t023_resp_latency", 64'(cyc - g1), 64'd1);
    checkOutput("t023_rdata0", rd, 64'h0);
    checkOutput("t023_err0", 64'(e), 64'h0);

    // Store then load from the other requester
    applyStimulus(0, 1'b1, 64'h10, 64'hDEADBEEFCAFEF00D, lat, g1);
    waitResp(0, rd, e);
    checkOutput("t024_store_rdata", rd, 64'h0);
    checkOutput("t024_store_err", 64'(e), 64'h0);
    applyStimulus(1, 1'b0, 64'h10, '0, lat, g1);
    waitResp(1, rd, e);
    checkOutput("t024_rdata1", rd, 64'hDEADBEEFCAFEF00D);
    checkOutput("t024_model_rd", expRd1, 64'hDEADBEEFCAFEF00D);

    // Faulting addresses: misaligned and beyond the memory, loads and stores
    applyStimulus(1, 1'b0, 64'h0C, '0, lat, g1);
    waitResp(1, rd, e);
    checkOutput("t026_misalign_err", 64'(e), 64'h1);
    checkOutput("t026_misalign_rdata", rd, 64'h0);
    applyStimulus(1, 1'b0, 64'h2000, '0, lat, g1);
    waitResp(1, rd, e);
    checkOutput("t026_range_err", 64'(e), 64'h1);
    checkOutput("t026_range_rdata", rd, 64'h0);
    applyStimulus(1, 1'b1, 64'h0C, 64'h1111, lat, g1);
    waitResp(1, rd, e);
    checkOutput("t026_misalign_store_err", 64'(e), 64'h1);
    applyStimulus(1, 1'b1, 64'h2000, 64'h2222, lat, g1);
    waitResp(1, rd, e);
    checkOutput("t026_range_store_err", 64'(e), 64'h1);
    applyStimulus(1, 1'b0, 64'h08, '0, lat, g1);
    waitResp(1, rd, e);
    checkOutput("t026_mem08_unchanged", rd, 64'h0);
    applyStimulus(1, 1'b0, 64'h00, '0, lat, g1);
    waitResp(1, rd, e);
    checkOutput("t026_mem00_unchanged", rd, 64'h0);

    // Reset during the grant cycle of a store cancels it
    drive(0, 1'b1, 1'b1, 64'h08, 64'h1);
    @(negedge clk);
    checkOutput("t027_gnt0", 64'(gnt0), 64'h1);
    #2 rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("t027_no_rvalid", 64'(rvalid0), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("t027_model_mem", mem[1], 64'h0);
    applyStimulus(0, 1'b0, 64'h08, '0, lat, g1);
    waitResp(0, rd, e);
    checkOutput("t027_load08", rd, 64'h0);

    // Back-to-back: new request raised during the response cycle
    applyStimulus(0, 1'b0, 64'h10, '0, lat, g1);
    waitResp(0, rd, e);
    applyStimulus(0, 1'b0, 64'h18, '0, lat, g2);
    checkOutput("t028_gnt_latency", 64'(lat), 64'd1);
    checkOutput("t028_gnt_spacing", 64'(g2 - g1), 64'd2);
    waitResp(0, rd, e);
    checkOutput("t028_rdata0", rd, 64'h0);

    // Contention from reset: grants alternate 0,1,0,1 every two cycles
    pulseReset();
    drive(0, 1'b1, 1'b0, 64'h10, '0);
    drive(1, 1'b1, 1'b0, 64'h18, '0);
    ng = 0;
    for (int n = 0; n < 30 && ng < 5; n++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        order[ng] = gnt1 ? 1 : 0;
        gcyc[ng]  = cyc;
        ng++;
        if (ng >= 4) drive(order[ng-1], 1'b0, 1'b0, '0, '0);
        else         drive(order[ng-1], 1'b1, 1'b0, 64'(ng) << 3, '0);
      end
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    checkOutput("t025_grant_count", 64'(ng), 64'd5);
    for (int k = 0; k < 4 && k < ng; k++) begin
      checkOutput($sformatf("t025_order%0d", k), 64'(order[k]), 64'(k % 2));
      if (k > 0) checkOutput($sformatf("t025_spacing%0d", k), 64'(gcyc[k] - gcyc[k-1]), 64'd2);
    end
    repeat (3) @(negedge clk);

    // Random concurrent traffic from both requesters
    fork
      randomRequester(0, 120);
      randomRequester(1, 120);
    join
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
